// File: rtl/csr_file_if.sv
// rtl/csr_file_if.sv - CSR access, commit, interrupt and front-end signals of csr_file
interface csr_file_if;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        exception_submit;
    logic [5:0]  ecode_submit;
    logic [8:0]  esubcode_submit;
    logic [31:0] exception_pc_submit;
    logic [31:0] exception_maddr_submit;
    logic        ertn_submit;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry;
    logic [31:0] ertn_era;
    logic        has_int;

    modport master (
        output csr_num, csr_we, csr_wmask, csr_wvalue,
               exception_submit, ecode_submit, esubcode_submit,
               exception_pc_submit, exception_maddr_submit, ertn_submit,
               hw_int_in, ipi_int_in,
        input  csr_rvalue, ex_entry, ertn_era, has_int
    );

    modport slave (
        input  csr_num, csr_we, csr_wmask, csr_wvalue,
               exception_submit, ecode_submit, esubcode_submit,
               exception_pc_submit, exception_maddr_submit, ertn_submit,
               hw_int_in, ipi_int_in,
        output csr_rvalue, ex_entry, ertn_era, has_int
    );
endinterface

// File: rtl/csr_file.sv
// rtl/csr_file.sv - LoongArch CSR file: masked CSR access, exception/ertn state, timer, interrupts
module csr_file #(
    parameter logic [31:0] TID_RESET = 32'h0
) (
    input  logic      clk,
    input  logic      rst,
    csr_file_if.slave bus
);
    localparam logic [13:0] CSR_CRMD   = 14'h00;
    localparam logic [13:0] CSR_PRMD   = 14'h01;
    localparam logic [13:0] CSR_ECFG   = 14'h04;
    localparam logic [13:0] CSR_ESTAT  = 14'h05;
    localparam logic [13:0] CSR_ERA    = 14'h06;
    localparam logic [13:0] CSR_BADV   = 14'h07;
    localparam logic [13:0] CSR_EENTRY = 14'h0C;
    localparam logic [13:0] CSR_SAVE0  = 14'h30;
    localparam logic [13:0] CSR_SAVE1  = 14'h31;
    localparam logic [13:0] CSR_SAVE2  = 14'h32;
    localparam logic [13:0] CSR_SAVE3  = 14'h33;
    localparam logic [13:0] CSR_TID    = 14'h40;
    localparam logic [13:0] CSR_TCFG   = 14'h41;
    localparam logic [13:0] CSR_TVAL   = 14'h42;
    localparam logic [13:0] CSR_TICLR  = 14'h44;
    localparam logic [5:0]  ECODE_ADEF = 6'h08;
    localparam logic [5:0]  ECODE_ALE  = 6'h09;

    logic [4:0]  crmd_q,   crmd_d;
    logic [2:0]  prmd_q,   prmd_d;
    logic [12:0] lie_q,    lie_d;
    logic [1:0]  is_sw_q,  is_sw_d;
    logic [7:0]  is_hw_q,  is_hw_d;
    logic        is_tmr_q, is_tmr_d;
    logic        is_ipi_q, is_ipi_d;
    logic [5:0]  ecode_q,  ecode_d;
    logic [8:0]  esub_q,   esub_d;
    logic [31:0] era_q,    era_d;
    logic [31:0] badv_q,   badv_d;
    logic [25:0] eentry_q, eentry_d;
    logic [31:0] save0_q,  save0_d;
    logic [31:0] save1_q,  save1_d;
    logic [31:0] save2_q,  save2_d;
    logic [31:0] save3_q,  save3_d;
    logic [31:0] tid_q,    tid_d;
    logic [31:0] tcfg_q,   tcfg_d;
    logic [31:0] tval_q,   tval_d;

    logic [31:0] estat_val;
    logic [12:0] is_all;
    logic [31:0] rvalue;
    logic [31:0] wnew;
    logic        wr_en;
    logic        timer_fire;

    assign is_all    = {is_ipi_q, is_tmr_q, 1'b0, is_hw_q, is_sw_q};
    assign estat_val = {1'b0, esub_q, ecode_q, 3'b000, is_all};

    always_comb begin
        rvalue = 32'h0;
        case (bus.csr_num)
            CSR_CRMD:   rvalue = {27'h0, crmd_q};
            CSR_PRMD:   rvalue = {29'h0, prmd_q};
            CSR_ECFG:   rvalue = {19'h0, lie_q};
            CSR_ESTAT:  rvalue = estat_val;
            CSR_ERA:    rvalue = era_q;
            CSR_BADV:   rvalue = badv_q;
            CSR_EENTRY: rvalue = {eentry_q, 6'h0};
            CSR_SAVE0:  rvalue = save0_q;
            CSR_SAVE1:  rvalue = save1_q;
            CSR_SAVE2:  rvalue = save2_q;
            CSR_SAVE3:  rvalue = save3_q;
            CSR_TID:    rvalue = tid_q;
            CSR_TCFG:   rvalue = tcfg_q;
            CSR_TVAL:   rvalue = tval_q;
            default:    rvalue = 32'h0;
        endcase
    end

    // The read value doubles as the "old" operand of the masked write.
    assign wnew  = (rvalue & ~bus.csr_wmask) | (bus.csr_wvalue & bus.csr_wmask);
    assign wr_en = bus.csr_we & ~bus.exception_submit & ~bus.ertn_submit;

    always_comb begin
        crmd_d     = crmd_q;
        prmd_d     = prmd_q;
        lie_d      = lie_q;
        is_sw_d    = is_sw_q;
        is_hw_d    = bus.hw_int_in;
        is_tmr_d   = is_tmr_q;
        is_ipi_d   = bus.ipi_int_in;
        ecode_d    = ecode_q;
        esub_d     = esub_q;
        era_d      = era_q;
        badv_d     = badv_q;
        eentry_d   = eentry_q;
        save0_d    = save0_q;
        save1_d    = save1_q;
        save2_d    = save2_q;
        save3_d    = save3_q;
        tid_d      = tid_q;
        tcfg_d     = tcfg_q;
        tval_d     = tval_q;
        timer_fire = 1'b0;

        if (wr_en) begin
            case (bus.csr_num)
                CSR_CRMD:   crmd_d   = wnew[4:0];
                CSR_PRMD:   prmd_d   = wnew[2:0];
                CSR_ECFG:   lie_d    = {wnew[12:11], 1'b0, wnew[9:0]};
                CSR_ESTAT:  is_sw_d  = wnew[1:0];
                CSR_ERA:    era_d    = wnew;
                CSR_BADV:   badv_d   = wnew;
                CSR_EENTRY: eentry_d = wnew[31:6];
                CSR_SAVE0:  save0_d  = wnew;
                CSR_SAVE1:  save1_d  = wnew;
                CSR_SAVE2:  save2_d  = wnew;
                CSR_SAVE3:  save3_d  = wnew;
                CSR_TID:    tid_d    = wnew;
                CSR_TCFG:   tcfg_d   = wnew;
                default:    ;
            endcase
        end

        if (bus.exception_submit) begin
            prmd_d       = crmd_q[2:0];
            crmd_d[2:0]  = 3'b000;
            ecode_d      = bus.ecode_submit;
            esub_d       = bus.esubcode_submit;
            era_d        = bus.exception_pc_submit;
            if (bus.ecode_submit == ECODE_ADEF)
                badv_d = bus.exception_pc_submit;
            else if (bus.ecode_submit == ECODE_ALE)
                badv_d = bus.exception_maddr_submit;
        end else if (bus.ertn_submit) begin
            crmd_d[2:0] = prmd_q;
        end

        // A TCFG write reloads the counter regardless of En and pre-empts the countdown.
        if (wr_en && bus.csr_num == CSR_TCFG) begin
            tval_d = {wnew[31:2], 2'b00};
        end else if (tcfg_q[0] && tval_q != 32'h0) begin
            if (tval_q == 32'h1) begin
                timer_fire = 1'b1;
                tval_d     = tcfg_q[1] ? {tcfg_q[31:2], 2'b00} : 32'h0;
            end else begin
                tval_d = tval_q - 32'h1;
            end
        end

        if (timer_fire)
            is_tmr_d = 1'b1;
        else if (wr_en && bus.csr_num == CSR_TICLR && wnew[0])
            is_tmr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crmd_q   <= 5'h08;
            prmd_q   <= 3'h0;
            lie_q    <= 13'h0;
            is_sw_q  <= 2'h0;
            is_hw_q  <= 8'h0;
            is_tmr_q <= 1'b0;
            is_ipi_q <= 1'b0;
            ecode_q  <= 6'h0;
            esub_q   <= 9'h0;
            era_q    <= 32'h0;
            badv_q   <= 32'h0;
            eentry_q <= 26'h0;
            save0_q  <= 32'h0;
            save1_q  <= 32'h0;
            save2_q  <= 32'h0;
            save3_q  <= 32'h0;
            tid_q    <= TID_RESET;
            tcfg_q   <= 32'h0;
            tval_q   <= 32'h0;
        end else begin
            crmd_q   <= crmd_d;
            prmd_q   <= prmd_d;
            lie_q    <= lie_d;
            is_sw_q  <= is_sw_d;
            is_hw_q  <= is_hw_d;
            is_tmr_q <= is_tmr_d;
            is_ipi_q <= is_ipi_d;
            ecode_q  <= ecode_d;
            esub_q   <= esub_d;
            era_q    <= era_d;
            badv_q   <= badv_d;
            eentry_q <= eentry_d;
            save0_q  <= save0_d;
            save1_q  <= save1_d;
            save2_q  <= save2_d;
            save3_q  <= save3_d;
            tid_q    <= tid_d;
            tcfg_q   <= tcfg_d;
            tval_q   <= tval_d;
        end
    end

    assign bus.csr_rvalue = rvalue;
    assign bus.ex_entry   = {eentry_q, 6'h0};
    assign bus.ertn_era   = era_q;
    assign bus.has_int    = crmd_q[2] & (|(is_all & lie_q));
endmodule
